// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the crossy-road game-flow controller.
//   - FSM state codes (3-bit encoding, visible on the state output)
//   - screen geometry constants used across the datapath
//   - default frame-tick divider (50 MHz clock, 60 Hz frame rate)
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_GOAL = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int LANE_H   = 20;
    localparam int GOAL_Y   = 0;

    localparam int DEFAULT_TICK_DIV = 833333;

endpackage

// File: rtl/game_sequencer_frame_tick_gen.sv
// Free-running frame tick generator.
// Counts 0..TICK_DIV-1 and wraps; frame_tick is high for the single cycle
// in which the counter holds TICK_DIV-1.
// Ports:
//   CLK        in  system clock
//   resetn     in  asynchronous active-low reset (counter cleared to 0)
//   frame_tick out one-cycle pulse every TICK_DIV cycles
module frame_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic CLK,
    input  logic resetn,
    output logic frame_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last     = (r_cnt == LAST);
    assign frame_tick = w_last;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences start, play, hit, goal and game-over,
// and keeps lives, score and level for the crossy-road datapath.
// Ports:
//   CLK, resetn        clock, asynchronous active-low reset
//   go                 start/restart request (level; only its rising edge acts)
//   hit                collision flag, active-low (0 = collision)
//   y_dot              player row, 0 = goal row
//   frame_tick         one-cycle pulse per frame
//   move_en            lane movers advance this cycle
//   speed              lane step size = level + 1 (3-bit, wraps)
//   player_rst         reload player to the start row
//   lives/score/level  game counters
//   state              current FSM state code
//   game_over          high while in OVER
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = DEFAULT_TICK_DIV,
    parameter int START_LIVES = 3,
    parameter int HIT_FRAMES  = 30,
    parameter int MAX_LEVEL   = 7
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic       go,
    input  logic       hit,
    input  logic [6:0] y_dot,
    output logic       frame_tick,
    output logic       move_en,
    output logic [2:0] speed,
    output logic       player_rst,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [2:0] level,
    output logic [2:0] state,
    output logic       game_over
);

    localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES + 1) : 1;
    localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_go_q;
    logic [1:0]    r_lives;
    logic [7:0]    r_score;
    logic [2:0]    r_level;
    logic [HW-1:0] r_hit_cnt;

    logic w_tick;
    logic w_go_rise;
    logic w_start;
    logic w_take_hit;
    logic w_take_goal;
    logic w_move_en;
    logic w_player_rst;
    logic w_game_over;

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK        (CLK),
        .resetn     (resetn),
        .frame_tick (w_tick)
    );

    assign w_go_rise = go & ~r_go_q;

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_take_hit   = 1'b0;
        w_take_goal  = 1'b0;
        w_move_en    = 1'b0;
        w_player_rst = 1'b0;
        w_game_over  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_player_rst = 1'b1;
                if (w_go_rise) begin
                    w_start      = 1'b1;
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_move_en = w_tick;
                // A collision on the goal row still counts as a collision.
                if (!hit) begin
                    w_take_hit   = 1'b1;
                    w_next_state = ST_HIT;
                end else if (y_dot == 7'(GOAL_Y)) begin
                    w_next_state = ST_GOAL;
                end
            end
            ST_HIT: begin
                if (r_hit_cnt == HIT_LAST) begin
                    if (r_lives == 2'd0) begin
                        w_next_state = ST_OVER;
                    end else begin
                        w_player_rst = 1'b1;
                        w_next_state = ST_PLAY;
                    end
                end
            end
            ST_GOAL: begin
                w_take_goal  = 1'b1;
                w_player_rst = 1'b1;
                w_next_state = ST_PLAY;
            end
            ST_OVER: begin
                w_game_over  = 1'b1;
                w_player_rst = 1'b1;
                if (w_go_rise) begin
                    w_start      = 1'b1;
                    w_next_state = ST_PLAY;
                end
            end
            default: begin
                w_player_rst = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_go_q    <= 1'b0;
            r_lives   <= 2'd0;
            r_score   <= 8'd0;
            r_level   <= 3'd0;
            r_hit_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_go_q  <= go;
            if (w_start) begin
                r_lives <= 2'(START_LIVES);
                r_score <= 8'd0;
                r_level <= 3'd0;
            end
            if (w_take_hit) begin
                r_hit_cnt <= '0;
                if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
            end else if (r_state == ST_HIT && w_tick && r_hit_cnt != HIT_LAST) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_take_goal) begin
                if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                if (r_level < 3'(MAX_LEVEL)) r_level <= r_level + 3'd1;
            end
        end
    end

    assign frame_tick = w_tick;
    assign move_en    = w_move_en;
    assign player_rst = w_player_rst;
    assign game_over  = w_game_over;
    assign lives      = r_lives;
    assign score      = r_score;
    assign level      = r_level;
    assign speed      = r_level + 3'd1;
    assign state      = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

  logic       CLK;
  logic       resetn;
  logic       go;
  logic       hit;
  logic [6:0] y_dot;
  logic       frame_tick;
  logic       move_en;
  logic [2:0] speed;
  logic       player_rst;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] level;
  logic [2:0] state;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_level;
  logic [7:0] exp_score;

  game_sequencer #(
    .TICK_DIV(4), .START_LIVES(3), .HIT_FRAMES(2), .MAX_LEVEL(7)
  ) dut (
    .CLK(CLK), .resetn(resetn), .go(go), .hit(hit), .y_dot(y_dot),
    .frame_tick(frame_tick), .move_en(move_en), .speed(speed),
    .player_rst(player_rst), .lives(lives), .score(score), .level(level),
    .state(state), .game_over(game_over)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget, input string tag);
    int n = 0;
    while (state !== want && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(state), 32'(want));
  endtask

  // One collision and its freeze period; counts ticks, move_en and player_rst
  // pulses seen while in HIT.
  task automatic do_hit(input logic [1:0] exp_lives, input logic [2:0] exp_after, input logic hold_go);
    int ticks = 0;
    int mv = 0;
    int pr = 0;
    int n = 0;
    hit = 1'b0;
    step();
    hit = 1'b1;
    if (hold_go) go = 1'b1;
    check("hit_state", 32'(state), 32'd2);
    check("hit_lives", 32'(lives), 32'(exp_lives));
    while (state === 3'd2 && n < 40) begin
      ticks += int'(frame_tick);
      mv    += int'(move_en);
      pr    += int'(player_rst);
      step();
      n++;
    end
    check("hit_ticks", 32'(ticks), 32'd2);
    check("hit_move_en", 32'(mv), 32'd0);
    check("hit_prst", 32'(pr), (exp_after == 3'd1) ? 32'd1 : 32'd0);
    check("hit_exit", 32'(state), 32'(exp_after));
  endtask

  task automatic do_goal();
    exp_level = (exp_level < 3'd7) ? exp_level + 3'd1 : 3'd7;
    exp_score = exp_score + 8'd1;
    exp_q.push_back(exp_level);
    y_dot = 7'd0;
    step();
    y_dot = 7'd60;
    check("goal_state", 32'(state), 32'd3);
    check("goal_prst", 32'(player_rst), 32'd1);
    step();
    check("goal_back", 32'(state), 32'd1);
    check("goal_score", 32'(score), 32'(exp_score));
    check("goal_level", 32'(level), 32'(exp_q.pop_front()));
    check("goal_speed", 32'(speed), 32'(3'(exp_level + 3'd1)));
  endtask

  task automatic go_pulse();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  initial begin
    int last_tick;
    int n_tick;
    int gap_bad;
    int mv_bad;
    resetn = 1'b0; go = 1'b0; hit = 1'b1; y_dot = 7'd60;
    exp_level = 3'd0; exp_score = 8'd0;
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_speed", 32'(speed), 32'd1);
    check("rst_prst", 32'(player_rst), 32'd1);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_move", 32'(move_en), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    #9 resetn = 1'b1;
    step();
    step();
    check("idle_hold", 32'(state), 32'd0);

    // 1: start
    go_pulse();
    check("start_state", 32'(state), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    check("start_score", 32'(score), 32'd0);
    check("start_level", 32'(level), 32'd0);
    check("start_speed", 32'(speed), 32'd1);
    check("start_prst", 32'(player_rst), 32'd0);
    last_tick = -1; n_tick = 0; gap_bad = 0; mv_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0 && i - last_tick != 4) gap_bad++;
        last_tick = i;
        n_tick++;
      end
      if (move_en !== frame_tick) mv_bad++;
      step();
    end
    check("tick_count", 32'(n_tick), 32'd3);
    check("tick_gap", 32'(gap_bad), 32'd0);
    check("move_eq_tick", 32'(mv_bad), 32'd0);

    // 2: single hit
    do_hit(2'd2, 3'd1, 1'b0);

    // 3: goals, level saturates at 7
    for (int g = 0; g < 8; g++) do_goal();
    check("sat_level", 32'(level), 32'd7);
    check("sat_speed", 32'(speed), 32'd0);
    check("sat_score", 32'(score), 32'd8);

    // 4: collision wins over goal
    hit = 1'b0; y_dot = 7'd0;
    step();
    hit = 1'b1; y_dot = 7'd60;
    check("both_state", 32'(state), 32'd2);
    check("both_score", 32'(score), 32'd8);
    check("both_lives", 32'(lives), 32'd1);
    wait_state(3'd1, 40, "both_back");

    // 5: fresh game, lose all lives
    resetn = 1'b0;
    #2 resetn = 1'b1;
    step();
    go_pulse();
    check("g2_state", 32'(state), 32'd1);
    exp_level = 3'd0; exp_score = 8'd0;
    do_goal();
    do_hit(2'd2, 3'd1, 1'b0);
    do_hit(2'd1, 3'd1, 1'b0);
    do_hit(2'd0, 3'd4, 1'b1);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_lives", 32'(lives), 32'd0);
    check("over_score", 32'(score), 32'd1);
    check("over_prst", 32'(player_rst), 32'd1);
    check("over_move", 32'(move_en), 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("over_held_go", 32'(state), 32'd4);
    go = 1'b0;
    step();
    go_pulse();
    check("restart_state", 32'(state), 32'd1);
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_score", 32'(score), 32'd0);
    check("restart_level", 32'(level), 32'd0);
    check("restart_over", 32'(game_over), 32'd0);

    // 6: asynchronous reset mid-HIT
    hit = 1'b0;
    step();
    hit = 1'b1;
    check("pre_rst_state", 32'(state), 32'd2);
    step();
    #2 resetn = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_lives", 32'(lives), 32'd0);
    check("arst_prst", 32'(player_rst), 32'd1);
    check("arst_move", 32'(move_en), 32'd0);
    #2 resetn = 1'b1;
    step();
    check("arst_idle", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the crossy-road datapath. It generates the per-frame tick, enables lane car movement, and consumes the collision flag from the lane collision detector and the player's y position. It sequences start, play, hit, goal and game-over, and maintains lives, score and level. It sits between the keyboard/`go` input, the lane movers, the player-dot mover and the collision detector.

Parameters:
TICK_DIV, 833333, CLK cycles per frame tick (50 MHz / 60 Hz); must be >= 2.
START_LIVES, 3, lives loaded at game start (1..3).
HIT_FRAMES, 30, frame ticks spent frozen after a collision (>= 1).
MAX_LEVEL, 7, level saturation value (<= 7).

Ports:
CLK  in  1  system clock, all state on rising edge.
resetn  in  1  asynchronous active-low reset.
go  in  1  start/restart request, level input, sampled synchronously.
hit  in  1  collision flag from the lane collision detector; 0 = collision (active-low).
y_dot  in  7  player row, 0..119; 0 = goal row.
frame_tick  out  1  one-cycle pulse once per TICK_DIV cycles.
move_en  out  1  lane movers advance one step this cycle.
speed  out  3  lane step size = level + 1.
player_rst  out  1  reload player to start row.
lives  out  2  remaining lives.
score  out  8  goals reached, saturating.
level  out  3  current level.
state  out  3  current FSM state code.
game_over  out  1  high in OVER.

Behaviour:
- Reset (async, resetn=0): state=IDLE, tick counter=0, lives=0, score=0, level=0, hit-frame counter=0, go_q=0. Outputs: frame_tick=0, move_en=0, player_rst=1, game_over=0.
- go_q registers go every cycle. go_rise = go & ~go_q.
- Tick counter runs in every state. It counts 0..TICK_DIV-1 and wraps to 0. frame_tick=1 in the cycle the counter equals TICK_DIV-1.
- State codes: IDLE=0, PLAY=1, HIT=2, GOAL=3, OVER=4. Codes 5..7 are illegal and return to IDLE.
- IDLE: move_en=0, player_rst=1.
  - On go_rise: lives<=START_LIVES, score<=0, level<=0, go to PLAY.
- PLAY: move_en=frame_tick. player_rst=0.
  - hit==0: lives<=lives-1 (saturate at 0), hit-frame counter<=0, go to HIT.
  - Otherwise, if y_dot==0: go to GOAL.
  - If hit==0 and y_dot==0 in the same cycle, the collision wins.
- HIT: move_en=0. The hit input is ignored. The hit-frame counter increments on each frame_tick.
  - When the counter reaches HIT_FRAMES: if lives==0, go to OVER; else player_rst=1 for exactly that cycle and go to PLAY.
- GOAL: one cycle only.
  - score<=score+1, saturating at 255.
  - level<=level+1, saturating at MAX_LEVEL.
  - player_rst=1, go to PLAY.
- OVER: game_over=1, move_en=0, player_rst=1. lives, score and level are held.
  - On go_rise: same reinit as IDLE, go to PLAY.
- speed=level+1 at all times. It changes the cycle after GOAL.
- Latency: hit or goal affects state, lives and score one cycle after sampling. move_en drops in the same cycle state becomes HIT.
- A go held high does not retrigger. go_rise is ignored in PLAY, HIT and GOAL.
- Reset mid-game aborts immediately to the reset values; there is no pending action.

Decomposition:
- Shared package holds:
  - state codes (IDLE..OVER);
  - the screen constants SCREEN_W=160, SCREEN_H=120, LANE_H=20, GOAL_Y=0;
  - default TICK_DIV.
- Sub-module frame_tick_gen (parameter TICK_DIV; ports CLK, resetn, frame_tick) holds the tick counter.
- The FSM, lives, score and level counters stay in game_sequencer.

Test Plan (TICK_DIV=4, HIT_FRAMES=2, START_LIVES=3):
1. Reset, then go pulse -> state=1, lives=3, score=0, level=0, speed=1; frame_tick and move_en pulse every 4 cycles; player_rst=0.
2. In PLAY, hit=0 for 1 cycle -> state=2, lives=2, move_en=0 for 2 frame ticks; then player_rst 1-cycle pulse, state=1.
3. In PLAY, y_dot=0 -> one cycle in state=3, score=1, level=1, speed=2, player_rst pulse, back to state=1. Repeat 8 times -> level stays 7, speed 8 wraps to 0 per 3-bit width (check level=7).
4. hit=0 and y_dot=0 in the same cycle -> state=2, score unchanged, lives decremented.
5. Three hits -> after the third HIT period, state=4, game_over=1, lives=0. Holding go high from before OVER does nothing; a new rising edge of go gives state=1, lives=3, score=0.
6. Assert resetn=0 asynchronously mid-HIT -> outputs at reset values immediately (state=0, lives=0, player_rst=1) without waiting for a CLK edge.
